rv_fetch: RTL

//  Instruction fetch stage feeding the decode stage.
//  - Generates the word PC and drives the instruction bus request/ack handshake.
//  - Registers {pc, instr, valid} toward decode; honours decode stall and exec redirect (flush + target).
//  - Its outputs are the pc/bus-data pair consumed by decode and the pipeline trace monitor.

---
 rtl/rv_fetch.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_fetch.sv
// rv_fetch: instruction fetch stage - word PC generation, ibus req/ack handshake, registered {pc, instr, valid} to decode.
// Define RV_FETCH_SKID_EN for a 2-entry output skid buffer; the default build uses a single output register.
module rv_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [29:0] o_ibus_addr,
    output logic        o_ibus_req,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_data,
    output logic [29:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [29:0] i_flush_pc
);
    localparam logic [29:0] RESET_WORD = RESET_ADDR[31:2];

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic        req_q, req_nxt;
    logic [29:0] addr_q, addr_nxt;
    logic [29:0] tgt_q, tgt_nxt;

    // Head output slot; o_pc/o_instr/o_valid always come from here.
    logic [29:0] pc_p0, pc_p0_nxt;
    logic [31:0] instr_p0, instr_p0_nxt;
    logic        vld_p0, vld_p0_nxt;

    logic consume, ack_eff, push, free_after_push, slot_free;

`ifdef RV_FETCH_SKID_EN
    logic [29:0] pc_p1, pc_p1_nxt;
    logic [31:0] instr_p1, instr_p1_nxt;
    logic        vld_p1, vld_p1_nxt;

    // Entries are packed toward the head, so vld_p1 implies vld_p0.
    assign free_after_push = ~vld_p1 & (~vld_p0 | consume);
    assign slot_free       = ~(vld_p1 & ~consume);
`else
    logic stall_q;

    assign free_after_push = 1'b1;
    assign slot_free       = ~vld_p0 | consume;
`endif

    assign consume = vld_p0 & ~i_stall;
    assign ack_eff = i_ibus_ack & o_ibus_req;
    assign push    = (state == S_REQ) & ack_eff & ~i_flush;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_BOOT;
            req_q    <= 1'b0;
            addr_q   <= RESET_WORD;
            tgt_q    <= RESET_WORD;
            pc_p0    <= RESET_WORD;
            instr_p0 <= '0;
            vld_p0   <= 1'b0;
`ifdef RV_FETCH_SKID_EN
            pc_p1    <= RESET_WORD;
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
`else
            stall_q  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            req_q    <= req_nxt;
            addr_q   <= addr_nxt;
            tgt_q    <= tgt_nxt;
            pc_p0    <= pc_p0_nxt;
            instr_p0 <= instr_p0_nxt;
            vld_p0   <= vld_p0_nxt;
`ifdef RV_FETCH_SKID_EN
            pc_p1    <= pc_p1_nxt;
            instr_p1 <= instr_p1_nxt;
            vld_p1   <= vld_p1_nxt;
`else
            stall_q  <= i_stall;
`endif
        end
    end

    // A waiting bus request cannot be cancelled, so a flush against it must drain first.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        addr_nxt  = addr_q;
        tgt_nxt   = tgt_q;
        if (i_flush) begin
            if (o_ibus_req & ~i_ibus_ack) begin
                tgt_nxt   = i_flush_pc;
                state_nxt = S_DRAIN;
            end else begin
                req_nxt   = 1'b1;
                addr_nxt  = i_flush_pc;
                state_nxt = S_REQ;
            end
        end else begin
            case (state)
                S_BOOT: begin
                    req_nxt   = 1'b1;
                    addr_nxt  = RESET_WORD;
                    state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (ack_eff) begin
                        addr_nxt  = addr_q + 30'd1;
                        req_nxt   = free_after_push;
                        state_nxt = free_after_push ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        req_nxt   = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (ack_eff) begin
                        addr_nxt  = tgt_q;
                        state_nxt = S_REQ;
                    end
                end
                default: state_nxt = S_BOOT;
            endcase
        end
    end

    // Output slot update: pop on consume, then append the acked word behind whatever remains.
    always_comb begin
        pc_p0_nxt    = pc_p0;
        instr_p0_nxt = instr_p0;
        vld_p0_nxt   = vld_p0;
`ifdef RV_FETCH_SKID_EN
        pc_p1_nxt    = pc_p1;
        instr_p1_nxt = instr_p1;
        vld_p1_nxt   = vld_p1;
`endif
        if (i_flush) begin
            instr_p0_nxt = '0;
            vld_p0_nxt   = 1'b0;
`ifdef RV_FETCH_SKID_EN
            instr_p1_nxt = '0;
            vld_p1_nxt   = 1'b0;
`endif
        end else begin
            if (consume) begin
`ifdef RV_FETCH_SKID_EN
                pc_p0_nxt    = pc_p1;
                instr_p0_nxt = instr_p1;
                vld_p0_nxt   = vld_p1;
                instr_p1_nxt = '0;
                vld_p1_nxt   = 1'b0;
`else
                instr_p0_nxt = '0;
                vld_p0_nxt   = 1'b0;
`endif
            end
            if (push) begin
`ifdef RV_FETCH_SKID_EN
                if (!vld_p0_nxt) begin
                    pc_p0_nxt    = addr_q;
                    instr_p0_nxt = i_ibus_data;
                    vld_p0_nxt   = 1'b1;
                end else begin
                    pc_p1_nxt    = addr_q;
                    instr_p1_nxt = i_ibus_data;
                    vld_p1_nxt   = 1'b1;
                end
`else
                pc_p0_nxt    = addr_q;
                instr_p0_nxt = i_ibus_data;
                vld_p0_nxt   = 1'b1;
`endif
            end
        end
    end

    // Without the skid buffer, requests pause while decode holds the slot and for one cycle after release.
    always_comb begin
`ifdef RV_FETCH_SKID_EN
        o_ibus_req = req_q;
`else
        o_ibus_req = req_q & ~(vld_p0 & (i_stall | stall_q));
`endif
        o_ibus_addr = addr_q;
        o_pc        = pc_p0;
        o_instr     = instr_p0;
        o_valid     = vld_p0;
    end

endmodule
